// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main control unit of the multicycle datapath. It steps each instruction
// through FETCH, DECODE and its execute/memory/write-back states. It drives
// the ALU select code, the operand-mux selects and all register, memory and
// PC write enables.
//
// Moore machine: every output is decoded from the state register alone.
// There are two exceptions:
//   - pc_en also uses the ALU zero flag, so that beq can resolve.
//   - illegal_op also uses opcode/funct while the FSM is in DECODE.
// While rst is high, every output except the debug state is forced to zero,
// so an instruction aborted by reset performs no further writes.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   opcode      in   IR[31:26]
//   funct       in   IR[5:0]
//   zero        in   ALU zero flag (meaningful in BRANCH only)
//   alu_select  out  ALU code: 010 add, 011 sub, 001 slt, 111 and,
//                    110 equality, 000 pass b
//   alu_src_a   out  0=PC, 1=register A
//   alu_src_b   out  00=B, 01=4, 10=sext imm, 11=sext imm<<2
//   iord        out  memory address: 0=PC, 1=ALUOut
//   mem_write   out  memory write enable
//   ir_write    out  instruction register load
//   reg_dst     out  0=rt, 1=rd
//   mem_to_reg  out  0=ALUOut, 1=MDR
//   reg_write   out  register file write enable
//   pc_source   out  00=ALU result, 01=ALUOut, 10=jump target
//   pc_en       out  pc_write | (pc_write_cond & zero)
//   instr_done  out  high in the last state of each instruction
//   illegal_op  out  pulse in DECODE for an unsupported opcode/funct
//   state       out  current state (debug)
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int OP_W  = 6,
  parameter int SEL_W = 3,
  parameter int ST_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic [OP_W-1:0]  funct,
  input  logic             zero,
  output logic [SEL_W-1:0] alu_select,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       pc_source,
  output logic             pc_en,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [ST_W-1:0]  state
);

  typedef enum logic [ST_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [SEL_W-1:0] ALU_PASS = 3'b000;
  localparam logic [SEL_W-1:0] ALU_SLT  = 3'b001;
  localparam logic [SEL_W-1:0] ALU_ADD  = 3'b010;
  localparam logic [SEL_W-1:0] ALU_SUB  = 3'b011;
  localparam logic [SEL_W-1:0] ALU_EQ   = 3'b110;
  localparam logic [SEL_W-1:0] ALU_AND  = 3'b111;

  state_t state_q;
  state_t state_d;
  logic   pc_write;
  logic   pc_write_cond;
  logic   funct_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) ||
                    (funct == FN_AND) || (funct == FN_SLT);

  // Next-state and output decode.
  always_comb begin
    state_d       = S_FETCH;
    alu_select    = ALU_PASS;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    pc_source     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b01;
        alu_select = ALU_ADD;
        pc_write   = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode decodes.
        alu_src_b  = 2'b11;
        alu_select = ALU_ADD;
        case (opcode)
          OP_RTYPE: begin
            if (funct_ok) state_d = S_EXECUTE;
            else          illegal_op = 1'b1;
          end
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_select = ALU_ADD;
        // The IR still holds the instruction, so the opcode picks the path.
        state_d    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_ADD:  alu_select = ALU_ADD;
          FN_SUB:  alu_select = ALU_SUB;
          FN_AND:  alu_select = ALU_AND;
          FN_SLT:  alu_select = ALU_SLT;
          default: alu_select = ALU_PASS;
        endcase
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_select    = ALU_EQ;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_select = ALU_ADD;
        state_d    = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        // Unused codes 12-15: outputs stay inactive, recover to FETCH.
        state_d = S_FETCH;
      end
    endcase

    // Reset silences every output, so an interrupted instruction stops cleanly.
    if (rst) begin
      alu_select    = ALU_PASS;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      iord          = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      pc_source     = 2'b00;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
    end
  end

  assign pc_en = pc_write | (pc_write_cond & zero);
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;

  logic [2:0] alu_select;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic [1:0] pc_source;
  logic       pc_en, instr_done, illegal_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_select(alu_select), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .pc_source(pc_source),
    .pc_en(pc_en), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  // Observed vector:
  // {state, sel, src_a, src_b, iord, mw, irw, rd, m2r, rw, pcs, pc_en, done, ill}
  localparam int W = 21;
  logic [W-1:0] obs;
  assign obs = {state, alu_select, alu_src_a, alu_src_b, iord, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, pc_source, pc_en, instr_done, illegal_op};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] mk(input int st, input logic [2:0] sel, input logic a,
                                      input logic [1:0] b, input logic io, input logic mw,
                                      input logic irw, input logic rd, input logic m2r,
                                      input logic rw, input logic [1:0] pcs, input logic pce,
                                      input logic dn, input logic il);
    logic [3:0] s4;
    s4 = st[3:0];
    return {s4, sel, a, b, io, mw, irw, rd, m2r, rw, pcs, pce, dn, il};
  endfunction

  task automatic push(input string tag, input logic [W-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Expected per-cycle outputs of one instruction, starting at FETCH.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input string nm);
    logic       legal;
    logic [2:0] rsel;
    legal = 1'b1;
    rsel  = 3'b000;
    case (fn)
      6'b100000: rsel = 3'b010;
      6'b100010: rsel = 3'b011;
      6'b100100: rsel = 3'b111;
      6'b101010: rsel = 3'b001;
      default:   rsel = 3'b000;
    endcase
    case (op)
      6'b000000: legal = (fn == 6'b100000) || (fn == 6'b100010) ||
                         (fn == 6'b100100) || (fn == 6'b101010);
      6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    push({nm, ".fetch"}, mk(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));
    push({nm, ".decode"}, mk(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, !legal));
    if (legal) begin
      case (op)
        6'b100011: begin
          push({nm, ".memadr"}, mk(2, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
          push({nm, ".memrd"},  mk(3, 3'b000, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
          push({nm, ".memwb"},  mk(4, 3'b000, 0, 2'b00, 0, 0, 0, 0, 1, 1, 2'b00, 0, 1, 0));
        end
        6'b101011: begin
          push({nm, ".memadr"}, mk(2, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
          push({nm, ".memwr"},  mk(5, 3'b000, 0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 0, 1, 0));
        end
        6'b000000: begin
          push({nm, ".execute"}, mk(6, rsel, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
          push({nm, ".aluwb"},   mk(7, 3'b000, 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0, 1, 0));
        end
        6'b000100:
          push({nm, ".branch"}, mk(8, 3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, z, 1, 0));
        6'b001000: begin
          push({nm, ".addiex"}, mk(9, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
          push({nm, ".addiwb"}, mk(10, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1, 0));
        end
        default:
          push({nm, ".jump"}, mk(11, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1, 1, 0));
      endcase
    end
  endtask

  // Compare one expected entry per cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, obs, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input string nm);
    opcode = op;
    funct  = fn;
    zero   = z;
    push_instr(op, fn, z, nm);
    wait_drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Second reset cycle: state already FETCH, every output held at zero.
    opcode = 6'b100011;
    @(posedge clk); #1;
    push("reset", mk(0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(6'b100011, 6'b000000, 1'b1, "lw");
    run_instr(6'b101011, 6'b000000, 1'b0, "sw");
    run_instr(6'b000000, 6'b101010, 1'b0, "slt");
    run_instr(6'b000000, 6'b100010, 1'b1, "sub");
    run_instr(6'b000000, 6'b100100, 1'b0, "and");
    run_instr(6'b000000, 6'b100000, 1'b0, "add");
    run_instr(6'b000100, 6'b000000, 1'b1, "beq_taken");
    run_instr(6'b000100, 6'b000000, 1'b0, "beq_not");
    run_instr(6'b001000, 6'b000000, 1'b1, "addi");
    run_instr(6'b000010, 6'b000000, 1'b0, "j");
    run_instr(6'b111111, 6'b000000, 1'b0, "ill_op");
    run_instr(6'b000000, 6'b000001, 1'b1, "ill_funct");

    // Reset while lw sits in MEMRD: outputs silent, then FETCH, no reg_write.
    opcode = 6'b100011;
    funct  = 6'b000000;
    zero   = 1'b0;
    push("lw_abort.fetch",  mk(0, 3'b010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 0));
    push("lw_abort.decode", mk(1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    push("lw_abort.memadr", mk(2, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    push("lw_abort.rst",    mk(3, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_drain();
    run_instr(6'b101011, 6'b000000, 1'b0, "sw_after_abort");

    // Random instruction mix, zero toggled freely to show it only matters in BRANCH.
    for (int i = 0; i < 24; i++) begin
      int         k;
      logic [5:0] op;
      logic [5:0] fn;
      k  = $urandom_range(0, 9);
      fn = 6'b000000;
      case (k)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin op = 6'b000000; fn = 6'b100000; end
        3: begin op = 6'b000000; fn = 6'b100010; end
        4: begin op = 6'b000000; fn = 6'b100100; end
        5: begin op = 6'b000000; fn = 6'b101010; end
        6: op = 6'b000100;
        7: op = 6'b001000;
        8: op = 6'b000010;
        default: begin
          if ($urandom_range(0, 1) == 0) op = 6'b111111;
          else begin op = 6'b000000; fn = 6'b000111; end
        end
      endcase
      run_instr(op, fn, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit of the multicycle datapath; sits directly upstream of the ALU.
- Decodes opcode/funct from the instruction register and steps each instruction through its states.
- Drives the ALU `select` code, the operand-mux selects, and all register/memory/PC write enables.
- Consumes the ALU `zero` flag to resolve beq.

Parameters:
- OP_W, 6, opcode and funct field width.
- SEL_W, 3, ALU select width; must match the ALU `select` port.
- ST_W, 4, state register width.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  OP_W  IR[31:26].
- funct  input  OP_W  IR[5:0].
- zero  input  1  ALU zero flag (valid while alu_select=110).
- alu_select  output  SEL_W  ALU code: 010 add, 011 sub, 001 slt, 111 and, 110 equality→zero, 000 pass b.
- alu_src_a  output  1  0=PC, 1=register A.
- alu_src_b  output  2  00=register B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- iord  output  1  memory address: 0=PC, 1=ALUOut.
- mem_write  output  1  memory write enable.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  0=rt, 1=rd.
- mem_to_reg  output  1  0=ALUOut, 1=MDR.
- reg_write  output  1  register file write enable.
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- pc_en  output  1  pc_write | (pc_write_cond & zero).
- instr_done  output  1  high in the final state of each instruction.
- illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode/funct.
- state  output  ST_W  current state, for debug.

Behaviour:
- Moore FSM: one state register; all outputs are combinational from state only, except pc_en (uses zero) and illegal_op (uses opcode/funct in DECODE).
- Reset:
  - While rst=1, every enable/pulse output is 0 (pc_en, mem_write, ir_write, reg_write, instr_done, illegal_op).
  - alu_select=000; all mux selects are 0.
  - At the clock edge with rst=1, state<=FETCH(0).
  - The first cycle after rst falls is FETCH.
  - rst mid-instruction aborts it with no further writes.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Codes 12–15: outputs inactive, next state FETCH.
- Outputs per state (unlisted outputs are 0; alu_select defaults to 000):
  - FETCH: ir_write=1, src_a=0, src_b=01, sel=010, pc_source=00, pc_write=1. Next DECODE.
  - DECODE: src_a=0, src_b=11, sel=010 (branch target into ALUOut).
    - Next by opcode: 000000 R-type→EXECUTE; 100011 lw / 101011 sw→MEMADR; 000100 beq→BRANCH; 001000 addi→ADDIEX; 000010 j→JUMP.
    - Any other opcode→FETCH with illegal_op=1.
    - R-type with funct not in {100000, 100010, 100100, 101010}→FETCH with illegal_op=1.
  - MEMADR: src_a=1, src_b=10, sel=010. Next MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1. Next MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Next FETCH.
  - MEMWR: iord=1, mem_write=1, instr_done=1. Next FETCH.
  - EXECUTE: src_a=1, src_b=00; sel by funct: add 100000→010, sub 100010→011, and 100100→111, slt 101010→001. Next ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Next FETCH.
  - BRANCH: src_a=1, src_b=00, sel=110, pc_write_cond=1, pc_source=01, instr_done=1. Next FETCH.
  - ADDIEX: src_a=1, src_b=10, sel=010. Next ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Next FETCH.
  - JUMP: pc_source=10, pc_write=1, instr_done=1. Next FETCH.
- Latency (cycles including FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- funct is sampled combinationally in EXECUTE. IR must hold, since ir_write is asserted only in FETCH.
- zero is ignored outside BRANCH; pc_en never asserts from zero alone.

Test Plan:
- rst=1 for 2 cycles, then release → state=0, all enables 0 during reset; next cycle ir_write=1, pc_en=1, alu_select=010, alu_src_b=01.
- opcode=100011 → states 0,1,2,3,4; reg_write=1 and mem_to_reg=1 only in cycle 5; instr_done high only in cycle 5.
- opcode=000000, funct=101010 → EXECUTE alu_select=001; ALUWB reg_dst=1, reg_write=1. Repeat with 100010 → 011, 100100 → 111, 100000 → 010.
- opcode=000100 → BRANCH alu_select=110, pc_source=01:
  - zero=1 → pc_en=1.
  - zero=0 → pc_en=0.
  - Next state FETCH in both cases.
- opcode=111111 → DECODE illegal_op=1 for exactly one cycle, then FETCH; no reg_write or mem_write asserted. Same result for opcode=000000, funct=000001.
- Assert rst in MEMRD during lw → next cycle state=0, and reg_write is never asserted for that lw.
